mole_game_ctrl: RTL and testbench
=================================

// Module: mole_game_ctrl
// PURPOSE
//  Parametrised whack-a-mole game controller; successor to the fixed 4-mole,
//  button-timed game FSM. Owns the game sequencing between the board inputs
//  and the drawImage/VGA path. Generalises the design to NUM_MOLES moles, with
//  internal gap/window timers, LFSR mole selection, score, lives and a shrinking
//  mole window. Drives the one-hot LED status and a redraw pulse for the drawer.
// PARAMETERS
//  NUM_MOLES  4           number of moles/hit inputs (>=2)
//  GAP_TICKS  12_500_000  cycles with no mole shown between moles
//  MOLE_TICKS 50_000_000  initial cycles a mole stays up
//  MIN_TICKS  10_000_000  floor for the shrinking mole window
//  LIVES      3           misses allowed before game over (>=1)
//  SCORE_W    8           score width; score saturates at 2^SCORE_W-1
//  LFSR_SEED  16'hACE1    LFSR reset value; 0 is replaced by 16'h0001
// PORTS
//  iClock       in   1          system clock (CLOCK_50)
//  iResetn      in   1          synchronous reset, active low
//  iStart       in   1          start/restart button, active high, level
//  iHit         in   NUM_MOLES  hit buttons, active high, level, pre-synchronised
//  oState       out  3          state code: IDLE=0 GAP=1 UP=2 HIT=3 MISS=4 OVER=5
//  oMole        out  NUM_MOLES  one-hot active mole; 0 when no mole is up
//  oScore       out  SCORE_W    hits this game
//  oLives       out  $clog2(LIVES+1)  remaining lives
//  oLed         out  6          one-hot of oState (bit n = state n)
//  oRedraw      out  1          1-cycle pulse the cycle after oState changes
// BEHAVIOUR
//  - Reset (iResetn=0 at posedge, any state): state=IDLE, oMole=0, oScore=0,
//    oLives=LIVES, oLed=6'b000001, oRedraw=0, timer=0, window=MOLE_TICKS,
//    LFSR=seed, prevIdx=0; edge-detect regs load all-ones (held buttons give no edge).
//  - Edges: start/hit events are rising edges (input & ~prev); prev updates every cycle.
//  - LFSR: 16-bit Galois, mask 16'hB400, steps every cycle when out of reset.
//  - Pick: idx=LFSR%NUM_MOLES; if idx==prevIdx then idx=(idx+1)%NUM_MOLES.
//  - IDLE: start edge -> GAP, timer=GAP_TICKS-1, score=0, lives=LIVES, window=MOLE_TICKS.
//  - GAP: timer decrements; at timer==0 -> UP, latch idx, prevIdx=idx, timer=window-1.
//  - UP: oMole=1<<idx. Per cycle, priority: (1) any wrong-mole edge -> MISS;
//    (2) correct-mole edge -> HIT; (3) timer==0 -> MISS; else timer decrements.
//    Correct hit on the expiry cycle counts as HIT. Correct+wrong same cycle -> MISS.
//  - HIT (1 cycle): score+=1, saturating; window=max(window-(MOLE_TICKS>>4), MIN_TICKS);
//    -> GAP, timer=GAP_TICKS-1.
//  - MISS (1 cycle): if lives==1 -> OVER, lives=0; else lives-=1 -> GAP, timer=GAP_TICKS-1.
//  - OVER: oMole=0, score held; start edge -> GAP with score=0, lives=LIVES,
//    window=MOLE_TICKS, timer=GAP_TICKS-1.
//  - oMole is 0 in every state except UP. oLed is registered with oState, no lag.
//  - oRedraw is registered: high for exactly one cycle after each state change.
//  - Timer width = $clog2(max(GAP_TICKS,MOLE_TICKS)); all counters wrap-free
//    by construction.
//  - Hit edges outside UP, and start edges outside IDLE/OVER, are ignored.
// TESTING  (NUM_MOLES=4 GAP_TICKS=5 MOLE_TICKS=32 MIN_TICKS=28 LIVES=3 SCORE_W=4)
//  1 Reset with iHit=4'hF, iStart=1 held -> IDLE, oLed=000001, score 0, lives 3;
//    release reset with buttons still held -> no transition.
//  2 Start edge -> GAP for 5 cycles -> UP, oMole one-hot = model pick; correct hit
//    -> HIT 1 cycle, score=1, window=30, GAP, oRedraw pulses on each change.
//  3 No hit in UP -> MISS after 32 cycles, lives=2; correct hit on the expiry cycle -> HIT.
//  4 Correct and wrong hit same cycle -> MISS; 3 misses -> OVER, oMole=0;
//    start edge -> GAP, score=0, lives=3.
//  5 Repeated hits -> window 32,30,28,28 (floor held); 16+ hits -> score stays 15.
//  6 Reset asserted mid-UP -> IDLE next edge, all outputs at reset values; LFSR
//    sequence restarts from seed, with no back-to-back repeat of the same mole.

Source files
------------

// File: rtl/mole_game_ctrl_if.sv
// Board-side bundle for the whack-a-mole controller: buttons in, game status out.
interface mole_game_ctrl_if #(
   parameter int NUM_MOLES = 4,
   parameter int SCORE_W   = 8,
   parameter int LIVES     = 3
);
   localparam int LIVES_W = $clog2(LIVES + 1);

   logic                 iStart;
   logic [NUM_MOLES-1:0] iHit;
   logic [2:0]           oState;
   logic [NUM_MOLES-1:0] oMole;
   logic [SCORE_W-1:0]   oScore;
   logic [LIVES_W-1:0]   oLives;
   logic [5:0]           oLed;
   logic                 oRedraw;

   // Board / testbench side: drives the buttons, watches the status
   modport master (
      output iStart, iHit,
      input  oState, oMole, oScore, oLives, oLed, oRedraw
   );

   // Controller side
   modport slave (
      input  iStart, iHit,
      output oState, oMole, oScore, oLives, oLed, oRedraw
   );
endinterface

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game sequencer: gap/window timers, LFSR mole pick, score,
// lives and a window that shrinks with every hit down to a floor.
module mole_game_ctrl #(
   parameter int          NUM_MOLES  = 4,
   parameter int          GAP_TICKS  = 12_500_000,
   parameter int          MOLE_TICKS = 50_000_000,
   parameter int          MIN_TICKS  = 10_000_000,
   parameter int          LIVES      = 3,
   parameter int          SCORE_W    = 8,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic             iClock,
   input  logic             iResetn,
   mole_game_ctrl_if.slave  bus
);
   localparam int TW = $clog2((GAP_TICKS > MOLE_TICKS) ? GAP_TICKS : MOLE_TICKS);
   localparam int WW = $clog2(MOLE_TICKS + 1);
   localparam int IW = $clog2(NUM_MOLES);
   localparam int LW = $clog2(LIVES + 1);

   // An all-zero Galois LFSR would lock up, so a zero seed is replaced.
   localparam logic [15:0]        SEED       = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
   localparam logic [15:0]        LFSR_MASK  = 16'hB400;
   localparam logic [WW-1:0]      WIN_INIT   = WW'(MOLE_TICKS);
   localparam logic [WW-1:0]      WIN_STEP   = WW'(MOLE_TICKS >> 4);
   localparam logic [WW-1:0]      WIN_MIN    = WW'(MIN_TICKS);
   localparam logic [TW-1:0]      GAP_LOAD   = TW'(GAP_TICKS - 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
   localparam logic [LW-1:0]      LIVES_INIT = LW'(LIVES);
   localparam logic [IW-1:0]      IDX_LAST   = IW'(NUM_MOLES - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_GAP  = 3'd1,
      S_UP   = 3'd2,
      S_HIT  = 3'd3,
      S_MISS = 3'd4,
      S_OVER = 3'd5
   } state_t;

   state_t               state_q, state_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [WW-1:0]        window_q, window_d;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic [LW-1:0]        lives_q, lives_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [15:0]          lfsr_q, lfsr_next;
   logic                 start_prev_q;
   logic [NUM_MOLES-1:0] hit_prev_q;
   logic                 redraw_q;

   logic                 start_edge;
   logic [NUM_MOLES-1:0] hit_edge;
   logic [NUM_MOLES-1:0] mole_mask;
   logic                 right_hit, wrong_hit;
   logic [IW-1:0]        idx_raw, pick_idx;

   // Score stops at full scale instead of wrapping back to zero.
   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
      return (v == SCORE_MAX) ? v : v + 1'b1;
   endfunction

   // Window shrinks by MOLE_TICKS/16 per hit, clamped at the floor without underflow.
   function automatic logic [WW-1:0] shrink_window(input logic [WW-1:0] w);
      if (w <= WIN_MIN)              return WIN_MIN;
      if ((w - WIN_MIN) < WIN_STEP)  return WIN_MIN;
      return w - WIN_STEP;
   endfunction

   assign start_edge = bus.iStart & ~start_prev_q;
   assign hit_edge   = bus.iHit & ~hit_prev_q;
   assign mole_mask  = {{(NUM_MOLES-1){1'b0}}, 1'b1} << idx_q;
   assign right_hit  = |(hit_edge & mole_mask);
   assign wrong_hit  = |(hit_edge & ~mole_mask);

   assign lfsr_next  = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
   assign idx_raw    = IW'(lfsr_q % 16'(NUM_MOLES));
   // idx_q doubles as the previous mole, so the same mole never shows twice in a row.
   assign pick_idx   = (idx_raw != idx_q)    ? idx_raw :
                       (idx_raw == IDX_LAST) ? '0      : idx_raw + 1'b1;

   // Next-state and datapath updates for the game sequence.
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      window_d = window_q;
      score_d  = score_q;
      lives_d  = lives_q;
      idx_d    = idx_q;
      case (state_q)
         S_IDLE, S_OVER: begin
            if (start_edge) begin
               state_d  = S_GAP;
               timer_d  = GAP_LOAD;
               score_d  = '0;
               lives_d  = LIVES_INIT;
               window_d = WIN_INIT;
            end
         end
         S_GAP: begin
            if (timer_q == '0) begin
               state_d = S_UP;
               idx_d   = pick_idx;
               timer_d = TW'(window_q - 1'b1);
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         S_UP: begin
            if (wrong_hit)           state_d = S_MISS;
            else if (right_hit)      state_d = S_HIT;
            else if (timer_q == '0)  state_d = S_MISS;
            else                     timer_d = timer_q - 1'b1;
         end
         S_HIT: begin
            score_d  = sat_inc(score_q);
            window_d = shrink_window(window_q);
            state_d  = S_GAP;
            timer_d  = GAP_LOAD;
         end
         S_MISS: begin
            if (lives_q == LW'(1)) begin
               state_d = S_OVER;
               lives_d = '0;
            end else begin
               lives_d = lives_q - 1'b1;
               state_d = S_GAP;
               timer_d = GAP_LOAD;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register, datapath registers, LFSR and button history.
   always_ff @(posedge iClock) begin
      if (!iResetn) begin
         state_q      <= S_IDLE;
         timer_q      <= '0;
         window_q     <= WIN_INIT;
         score_q      <= '0;
         lives_q      <= LIVES_INIT;
         idx_q        <= '0;
         lfsr_q       <= SEED;
         start_prev_q <= 1'b1;
         hit_prev_q   <= '1;
         redraw_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         window_q     <= window_d;
         score_q      <= score_d;
         lives_q      <= lives_d;
         idx_q        <= idx_d;
         lfsr_q       <= lfsr_next;
         start_prev_q <= bus.iStart;
         hit_prev_q   <= bus.iHit;
         redraw_q     <= (state_d != state_q);
      end
   end

   assign bus.oState  = state_q;
   assign bus.oMole   = (state_q == S_UP) ? mole_mask : '0;
   assign bus.oScore  = score_q;
   assign bus.oLives  = lives_q;
   assign bus.oLed    = 6'b000001 << state_q;
   assign bus.oRedraw = redraw_q;
endmodule

// File: tb/tb_mole_game_ctrl.sv
// Directed bench for mole_game_ctrl with a small LFSR/pick model.
module tb_mole_game_ctrl;
   localparam int NM   = 4;
   localparam int GAP  = 5;
   localparam int MOLE = 32;
   localparam int MIN  = 28;
   localparam int LV   = 3;
   localparam int SW   = 4;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   mole_game_ctrl_if #(.NUM_MOLES(NM), .SCORE_W(SW), .LIVES(LV)) bus ();

   mole_game_ctrl #(
      .NUM_MOLES(NM), .GAP_TICKS(GAP), .MOLE_TICKS(MOLE), .MIN_TICKS(MIN),
      .LIVES(LV), .SCORE_W(SW), .LFSR_SEED(16'hACE1)
   ) dut (
      .iClock (clk),
      .iResetn(rst_n),
      .bus    (bus)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   logic [15:0] m_lfsr;
   int          m_prev;
   int          exp_idx;
   logic [3:0]  exp_mask;
   int          len;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
   endfunction

   // Reference LFSR: seed while in reset, one step per clock otherwise.
   always @(posedge clk) m_lfsr <= (!rst_n) ? 16'hACE1 : lfsr_step(m_lfsr);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_game();
      bus.iStart = 1'b1;
      tick();
      bus.iStart = 1'b0;
      chk("start_state",  32'(bus.oState), 1);
      chk("start_led",    32'(bus.oLed), 32'h02);
      chk("start_redraw", 32'(bus.oRedraw), 1);
      chk("start_score",  32'(bus.oScore), 0);
      chk("start_lives",  32'(bus.oLives), LV);
   endtask

   // Just entered GAP: four more GAP cycles, then UP on the fifth edge.
   task automatic gap_to_up(input bit noise);
      for (int k = 1; k <= 4; k++) begin
         if (noise && k == 2) begin
            bus.iStart = 1'b1;
            bus.iHit   = 4'hF;
         end else begin
            bus.iStart = 1'b0;
            bus.iHit   = 4'h0;
         end
         tick();
      end
      chk("gap_hold",   32'(bus.oState), 1);
      chk("gap_redraw", 32'(bus.oRedraw), 0);
      chk("gap_mole",   32'(bus.oMole), 0);
      exp_idx = int'(m_lfsr % 16'd4);
      if (exp_idx == m_prev) exp_idx = (exp_idx + 1) % 4;
      m_prev   = exp_idx;
      exp_mask = 4'b0001 << exp_idx;
      tick();
      chk("up_state",  32'(bus.oState), 2);
      chk("up_mole",   32'(bus.oMole), 32'(exp_mask));
      chk("up_led",    32'(bus.oLed), 32'h04);
      chk("up_redraw", 32'(bus.oRedraw), 1);
   endtask

   // In UP cycle 1; optionally press at UP cycle hit_cyc. Returns cycles spent in UP.
   task automatic run_up(input int hit_cyc, input logic [3:0] extra, output int up_len);
      up_len = 0;
      for (int k = 1; k <= 100; k++) begin
         bus.iHit = (k == hit_cyc) ? (exp_mask | extra) : 4'h0;
         tick();
         if (bus.oState != 3'd2) begin
            up_len = k;
            break;
         end
      end
      bus.iHit = 4'h0;
   endtask

   task automatic after_up(input bit is_hit, input int exp_score, input int exp_lives,
                           input bit to_over);
      chk("exit_state",  32'(bus.oState), is_hit ? 3 : 4);
      chk("exit_redraw", 32'(bus.oRedraw), 1);
      chk("exit_mole",   32'(bus.oMole), 0);
      tick();
      chk("post_state", 32'(bus.oState), to_over ? 5 : 1);
      chk("post_score", 32'(bus.oScore), exp_score);
      chk("post_lives", 32'(bus.oLives), exp_lives);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] wrong;
      rst_n      = 1'b0;
      bus.iStart = 1'b1;
      bus.iHit   = 4'hF;
      m_prev     = 0;
      tick();
      tick();
      chk("rst_state",  32'(bus.oState), 0);
      chk("rst_led",    32'(bus.oLed), 32'h01);
      chk("rst_score",  32'(bus.oScore), 0);
      chk("rst_lives",  32'(bus.oLives), 3);
      chk("rst_mole",   32'(bus.oMole), 0);
      chk("rst_redraw", 32'(bus.oRedraw), 0);

      // Release reset with buttons still held: no edge, stay IDLE.
      rst_n = 1'b1;
      repeat (3) tick();
      chk("held_state",  32'(bus.oState), 0);
      chk("held_redraw", 32'(bus.oRedraw), 0);
      bus.iStart = 1'b0;
      bus.iHit   = 4'h0;
      tick();

      // Game 1: window 32 -> 30 -> 28 -> 28, three misses end in OVER.
      start_game();
      gap_to_up(1'b0); run_up(1, 4'h0, len);  chk("g1_up1_len", len, 1);  after_up(1'b1, 1, 3, 1'b0);
      gap_to_up(1'b0); run_up(0, 4'h0, len);  chk("g1_win30", len, 30);   after_up(1'b0, 1, 2, 1'b0);
      gap_to_up(1'b0); run_up(2, 4'h0, len);  chk("g1_up3_len", len, 2);  after_up(1'b1, 2, 2, 1'b0);
      gap_to_up(1'b0); run_up(1, 4'h0, len);  chk("g1_up4_len", len, 1);  after_up(1'b1, 3, 2, 1'b0);
      gap_to_up(1'b0); run_up(0, 4'h0, len);  chk("g1_win28", len, 28);   after_up(1'b0, 3, 1, 1'b0);
      // Correct and wrong button on the same edge counts as a miss.
      gap_to_up(1'b0);
      wrong = (exp_mask == 4'b0001) ? 4'b0010 : 4'b0001;
      run_up(3, wrong, len);                  chk("g1_both_len", len, 3); after_up(1'b0, 3, 0, 1'b1);
      chk("over_led",  32'(bus.oLed), 32'h20);
      chk("over_mole", 32'(bus.oMole), 0);
      repeat (2) tick();
      chk("over_hold",   32'(bus.oState), 5);
      chk("over_score",  32'(bus.oScore), 3);
      chk("over_redraw", 32'(bus.oRedraw), 0);

      // Game 2: restart from OVER, full window miss, hit on expiry, saturation.
      start_game();
      gap_to_up(1'b1); run_up(0, 4'h0, len);  chk("g2_win32", len, 32);   after_up(1'b0, 0, 2, 1'b0);
      gap_to_up(1'b0); run_up(32, 4'h0, len); chk("g2_expiry_hit", len, 32); after_up(1'b1, 1, 2, 1'b0);
      for (int i = 2; i <= 17; i++) begin
         gap_to_up(1'b0);
         run_up(1, 4'h0, len);
         after_up(1'b1, (i > 15) ? 15 : i, 2, 1'b0);
      end

      // Reset in the middle of UP.
      gap_to_up(1'b0);
      tick();
      chk("mid_up_state", 32'(bus.oState), 2);
      rst_n = 1'b0;
      tick();
      m_prev = 0;
      chk("mrst_state",  32'(bus.oState), 0);
      chk("mrst_led",    32'(bus.oLed), 32'h01);
      chk("mrst_mole",   32'(bus.oMole), 0);
      chk("mrst_score",  32'(bus.oScore), 0);
      chk("mrst_lives",  32'(bus.oLives), 3);
      chk("mrst_redraw", 32'(bus.oRedraw), 0);
      rst_n = 1'b1;
      tick();

      // Pick sequence restarts from the seed.
      start_game();
      for (int i = 1; i <= 3; i++) begin
         gap_to_up(1'b0);
         run_up(1, 4'h0, len);
         after_up(1'b1, i, 3, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
